// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, counter sizing.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  // Iteration counter width for a given operand width; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultCntW  = cnt_width(DefaultWidth);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: shift-add multiply step or restoring-divide step on a 2*WIDTH
// accumulator ({upper, lower}).
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: lower half holds the remaining multiplier bits, LSB first.
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    // Divide: shift the partial remainder left by one, pulling in the next dividend bit.
    rem_sh  = acc_in[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, operand};
    acc_out = '0;
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO; one result bit per cycle.
// Optional MULDIV_ABORT_EN lets abort cancel an in-flight operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef MULDIV_ABORT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif

  state_e             state;
  logic [CntW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_orig;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;
  logic               b_zero;

  logic               is_muldiv;
  logic               signed_op;
  logic               div_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               abort_hit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    is_muldiv = ~op[2];
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    abort_hit = AbortEn && abort && (state != StIdle);
    prod_fix  = res_neg ? -acc : acc;
    quot_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_in (acc),
    .operand(operand),
    .is_div (is_div),
    .acc_out(acc_step)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= StIdle;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      a_orig  <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      b_zero  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && is_muldiv) begin
            state   <= StRun;
            busy    <= 1'b1;
            cnt     <= '0;
            div0    <= 1'b0;
            is_div  <= div_op;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            b_zero  <= (b == '0);
            a_orig  <= a;
            // Multiplier sits in the low half; dividend likewise for the divide.
            acc     <= {{WIDTH{1'b0}}, div_op ? a_mag : b_mag};
            operand <= div_op ? b_mag : a_mag;
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        StRun: begin
          if (abort_hit) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (cnt == LastCnt) begin
              state <= StFix;
            end
          end
        end
        StFix: begin
          state <= StIdle;
          busy  <= 1'b0;
          if (!abort_hit) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (b_zero) begin
              lo   <= '1;
              hi   <= a_orig;
              div0 <= 1'b1;
            end else begin
              lo <= quot_fix;
              hi <= rem_fix;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32) with hand-computed expectations.
module tb_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  int n_checks;
  int n_errors;

  muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .div0   (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one start strobe; returns 1ns after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done (0 on timeout) and cycles with busy high along the way.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = busy ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    int bc;
    issue(o, x, y);
    wait_done(lat, bc);
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  int lat;
  int bc;
  int pulses;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    a        = '0;
    b        = '0;
    abort    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // MULTU latency and busy window
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat, bc);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy_cyc", 64'(bc), 64'd33);
    check("multu_busy_at_done", 64'(busy), 64'd0);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
    @(posedge clk);
    #1;
    check("multu_done_once", 64'(done), 64'd0);

    run(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run(3'd3, 32'd100, 32'd7, "divu", 32'd2, 32'd14);
    run(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min", 32'h0, 32'h8000_0000);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, "multu_big", 32'h4000_0000, 32'h0);

    run(3'd3, 32'd5, 32'd0, "divu_zero", 32'd5, 32'hFFFF_FFFF);
    check("divu_zero_div0", 64'(div0), 64'd1);
    run(3'd2, 32'hFFFF_FFF8, 32'd0, "div_zero", 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    check("div_zero_div0", 64'(div0), 64'd1);
    issue(3'd1, 32'd2, 32'd3);
    check("div0_clear", 64'(div0), 64'd0);
    check("back2back_busy", 64'(busy), 64'd1);
    wait_done(lat, bc);
    check("mul23_hi", 64'(hi), 64'd0);
    check("mul23_lo", 64'(lo), 64'd6);

    // MTHI / MTLO / reserved op
    issue(3'd4, 32'h1234, 32'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_lo", 64'(lo), 64'd6);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(3'd5, 32'hBEEF, 32'd0);
    check("mtlo_lo", 64'(lo), 64'hBEEF);
    check("mtlo_hi", 64'(hi), 64'h1234);
    issue(3'd6, 32'hDEAD, 32'hDEAD);
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_hi", 64'(hi), 64'h1234);
    check("rsvd_lo", 64'(lo), 64'hBEEF);

    // Second start while busy is ignored; operand changes do not matter
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(posedge clk);
    issue(3'd0, 32'd5, 32'd5);
    a = 32'd77;
    b = 32'd99;
    wait_done(lat, bc);
    check("ignore_lat", 64'(lat), 64'd23);
    check("ignore_hi", 64'(hi), 64'h1);
    check("ignore_lo", 64'(lo), 64'h0);
    count_done(40, pulses);
    check("ignore_no_extra", 64'(pulses), 64'd0);
    check("ignore_idle", 64'(busy), 64'd0);

    // abort at cycle 5
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
`ifdef MULDIV_ABORT_EN
    check("abort_busy", 64'(busy), 64'd0);
    count_done(40, pulses);
    check("abort_no_done", 64'(pulses), 64'd0);
    check("abort_hi", 64'(hi), 64'h1);
    check("abort_lo", 64'(lo), 64'h0);
`else
    check("noabort_busy", 64'(busy), 64'd1);
    wait_done(lat, bc);
    check("noabort_lat", 64'(lat), 64'd28);
    check("noabort_hi", 64'(hi), 64'd2);
    check("noabort_lo", 64'(lo), 64'd14);
`endif

    // reset at cycle 10 of a DIV
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    count_done(40, pulses);
    check("rstmid_no_done", 64'(pulses), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
